// File: rtl/midi_poly_player.sv
// Polyphonic MIDI note player: parses note-on/off with running status, allocates notes
// across phase-accumulator voices (with round-robin stealing) and mixes them into one sample stream.
module midi_poly_player #(
  parameter int NUM_VOICES       = 4,
  parameter int OUTPUT_BITS      = 16,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int FREQ_SHIFT       = 2,
  parameter int SAMPLE_DIV       = 1,
  parameter int MIDI_CHANNEL     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             midi_data,
  input  logic                   midi_valid,
  input  logic [1:0]             wave_sel,
  output logic [OUTPUT_BITS-1:0] sound_data,
  output logic                   sound_valid,
  output logic [NUM_VOICES-1:0]  voices_active
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int MW = OUTPUT_BITS + VW;
  localparam logic             OMNI = (MIDI_CHANNEL > 15);
  localparam logic [3:0]       CHAN = 4'(MIDI_CHANNEL % 16);
  localparam logic [DW-1:0]    DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [OUTPUT_BITS-1:0] MID = {1'b1, {(OUTPUT_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, NOTE, VEL, SKIP} state_t;

  // Tone frequency in Hz: the top octave (notes 120..131) rounded from A=440 Hz,
  // halved once per octave below it.
  function automatic logic [13:0] midi_note_to_tone_freq(input logic [6:0] note);
    logic [13:0] top;
    logic [3:0]  oct;
    logic [3:0]  semi;
    oct  = 4'(note / 7'd12);
    semi = 4'(note % 7'd12);
    case (semi)
      4'd0:    top = 14'd8372;
      4'd1:    top = 14'd8870;
      4'd2:    top = 14'd9397;
      4'd3:    top = 14'd9956;
      4'd4:    top = 14'd10548;
      4'd5:    top = 14'd11175;
      4'd6:    top = 14'd11840;
      4'd7:    top = 14'd12544;
      4'd8:    top = 14'd13290;
      4'd9:    top = 14'd14080;
      4'd10:   top = 14'd14917;
      default: top = 14'd15804;
    endcase
    return top >> (4'd10 - oct);
  endfunction

  // ---------------- parser ----------------
  state_t     state, state_next;
  logic       is_on;
  logic [6:0] note_r;
  logic       type_load, note_load, fire;
  logic       ev_valid, ev_on;
  logic [6:0] ev_note;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_next = state;
    type_load  = 1'b0;
    note_load  = 1'b0;
    fire       = 1'b0;
    if (midi_valid && (midi_data < 8'hF8)) begin
      if (midi_data[7]) begin
        if ((midi_data[7:5] == 3'b100) && (OMNI || (midi_data[3:0] == CHAN))) begin
          type_load  = 1'b1;
          state_next = NOTE;
        end else begin
          state_next = SKIP;
        end
      end else begin
        case (state)
          NOTE: begin
            note_load  = 1'b1;
            state_next = VEL;
          end
          VEL: begin
            fire       = 1'b1;
            state_next = NOTE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state    <= IDLE;
      is_on    <= 1'b0;
      note_r   <= '0;
      ev_valid <= 1'b0;
      ev_on    <= 1'b0;
      ev_note  <= '0;
    end else begin
      state    <= state_next;
      ev_valid <= fire;
      if (type_load) is_on  <= midi_data[4];
      if (note_load) note_r <= midi_data[6:0];
      if (fire) begin
        ev_on   <= is_on && (midi_data[6:0] != 7'd0);
        ev_note <= note_r;
      end
    end
  end

  // ---------------- voice allocation ----------------
  logic [ACCUMULATOR_BITS-1:0] acc_q  [NUM_VOICES];
  logic [ACCUMULATOR_BITS-1:0] inc_q  [NUM_VOICES];
  logic [6:0]                  note_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]       active;
  logic [VW-1:0]               steal_ptr;

  logic [NUM_VOICES-1:0]       hit;
  logic                        hit_any, free_any;
  logic [VW-1:0]               hit_idx, free_idx, target;
  logic [ACCUMULATOR_BITS-1:0] ev_inc;
  logic                        tick;

  always_comb begin
    hit      = '0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      hit[i] = active[i] && (note_q[i] == ev_note);
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (hit[i])     hit_idx  = VW'(i);
      if (!active[i]) free_idx = VW'(i);
    end
    hit_any  = |hit;
    free_any = ~&active;
    target   = hit_any ? hit_idx : (free_any ? free_idx : steal_ptr);
    ev_inc   = ACCUMULATOR_BITS'(midi_note_to_tone_freq(ev_note)) << FREQ_SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the voice table is a handful of flops, not a RAM, so it is reset with everything else.
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        acc_q[i]  <= '0;
        inc_q[i]  <= '0;
        note_q[i] <= '0;
      end
      active    <= '0;
      steal_ptr <= '0;
    end else begin
      if (tick) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (active[i]) acc_q[i] <= acc_q[i] + inc_q[i];
      end
      // Placed after the tick update so a note-on clears the accumulator instead of advancing it.
      if (ev_valid) begin
        if (ev_on) begin
          active[target] <= 1'b1;
          note_q[target] <= ev_note;
          inc_q[target]  <= ev_inc;
          acc_q[target]  <= '0;
          if (!hit_any && !free_any) steal_ptr <= steal_ptr + 1'b1;
        end else if (hit_any) begin
          active[hit_idx] <= 1'b0;
        end
      end
    end
  end

  assign voices_active = active;

  // ---------------- waveform and mix ----------------
  logic [OUTPUT_BITS-1:0] mixed;

  always_comb begin : mix
    logic [MW-1:0]          sum;
    logic [OUTPUT_BITS-1:0] p;
    logic [OUTPUT_BITS-1:0] v;
    sum = '0;
    p   = '0;
    v   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      p = acc_q[i][ACCUMULATOR_BITS-1 -: OUTPUT_BITS];
      if (!active[i]) begin
        v = MID;
      end else begin
        case (wave_sel)
          2'd0:    v = p;
          2'd1:    v = p[OUTPUT_BITS-1] ? ~(p << 1) : (p << 1);
          2'd2:    v = p[OUTPUT_BITS-1] ? '1 : '0;
          default: v = MID;
        endcase
      end
      sum = sum + MW'(v);
    end
    mixed = OUTPUT_BITS'(sum >> VW);
  end

  // ---------------- sample divider and output ----------------
  logic [DW-1:0] div_q;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      sound_data  <= MID;
      sound_valid <= 1'b0;
    end else begin
      div_q       <= tick ? '0 : div_q + 1'b1;
      sound_valid <= tick;
      if (tick) sound_data <= mixed;
    end
  end

endmodule

// File: tb/tb_midi_poly_player.sv
// Bench for midi_poly_player: an omni/SAMPLE_DIV=1 instance and a channel-0/SAMPLE_DIV=3 instance
// share one byte stream and are compared every cycle against a behavioural MIDI/voice model.
module tb_midi_poly_player;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  midi_data = 8'h00;
  logic        midi_valid = 1'b0;
  logic [1:0]  wave_sel = 2'd0;
  logic [15:0] sd_a, sd_b;
  logic        sv_a, sv_b;
  logic [3:0]  va_a, va_b;

  midi_poly_player dut_omni (
    .clk(clk), .rst_n(rst_n), .midi_data(midi_data), .midi_valid(midi_valid),
    .wave_sel(wave_sel), .sound_data(sd_a), .sound_valid(sv_a), .voices_active(va_a)
  );

  midi_poly_player #(.MIDI_CHANNEL(0), .SAMPLE_DIV(3)) dut_ch0 (
    .clk(clk), .rst_n(rst_n), .midi_data(midi_data), .midi_valid(midi_valid),
    .wave_sel(wave_sel), .sound_data(sd_b), .sound_valid(sv_b), .voices_active(va_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // ---------------- behavioural model (index 0 = omni, 1 = channel 0) ----------------
  int          div_m [2] = '{1, 3};
  int          chan_m[2] = '{16, 0};
  bit          rs_valid[2], rs_on[2], have_note[2];
  int          pend_note[2];
  bit          ev_p[2], ev_on[2];
  int          ev_note[2];
  bit          act[2][NV];
  int          nt [2][NV];
  int unsigned inc[2][NV];
  int unsigned acc[2][NV];
  int          steal[2], divc[2];
  int          exp_data[2];
  bit          exp_valid[2];

  function automatic int model_freq(input int n);
    real f;
    int  t;
    f = 440.0 * (2.0 ** ((51 + n % 12) / 12.0));
    t = $rtoi(f + 0.5);
    return t >> (10 - n / 12);
  endfunction

  function automatic int contrib(input int k, input int v, input int ws);
    int p;
    if (!act[k][v] || ws == 3) return 32768;
    p = int'(acc[k][v] >> 8) & 32'hFFFF;
    case (ws)
      0:       return p;
      1:       return (p >= 32768) ? (~(p * 2)) & 32'hFFFF : (p * 2) & 32'hFFFF;
      default: return (p >= 32768) ? 65535 : 0;
    endcase
  endfunction

  task automatic model_reset(input int k);
    rs_valid[k] = 0; rs_on[k] = 0; have_note[k] = 0; pend_note[k] = 0;
    ev_p[k] = 0; ev_on[k] = 0; ev_note[k] = 0;
    steal[k] = 0; divc[k] = 0; exp_data[k] = 32768; exp_valid[k] = 0;
    for (int v = 0; v < NV; v++) begin
      act[k][v] = 0; nt[k][v] = 0; inc[k][v] = 0; acc[k][v] = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit valid, input int b, input int ws);
    bit tick, evp, evon;
    int evn, hit, tgt, sum;
    tick = (divc[k] == div_m[k] - 1);
    divc[k] = tick ? 0 : divc[k] + 1;
    exp_valid[k] = tick;
    if (tick) begin
      sum = 0;
      for (int v = 0; v < NV; v++) sum += contrib(k, v, ws);
      exp_data[k] = sum / NV;
      for (int v = 0; v < NV; v++)
        if (act[k][v]) acc[k][v] = (acc[k][v] + inc[k][v]) & 32'hFFFFFF;
    end
    evp = ev_p[k]; evon = ev_on[k]; evn = ev_note[k];
    ev_p[k] = 0;
    if (evp) begin
      hit = -1;
      for (int v = 0; v < NV; v++) if (act[k][v] && nt[k][v] == evn && hit < 0) hit = v;
      if (evon) begin
        tgt = hit;
        for (int v = 0; v < NV; v++) if (tgt < 0 && !act[k][v]) tgt = v;
        if (tgt < 0) begin
          tgt = steal[k];
          steal[k] = (steal[k] + 1) % NV;
        end
        act[k][tgt] = 1; nt[k][tgt] = evn; acc[k][tgt] = 0;
        inc[k][tgt] = int'(model_freq(evn)) << 2;
      end else if (hit >= 0) begin
        act[k][hit] = 0;
      end
    end
    if (valid && b < 'hF8) begin
      if (b >= 'h80) begin
        if (b < 'hA0 && (chan_m[k] == 16 || b % 16 == chan_m[k])) begin
          rs_valid[k] = 1; rs_on[k] = (b >= 'h90); have_note[k] = 0;
        end else begin
          rs_valid[k] = 0;
        end
      end else if (rs_valid[k]) begin
        if (!have_note[k]) begin
          pend_note[k] = b; have_note[k] = 1;
        end else begin
          ev_p[k] = 1; ev_on[k] = rs_on[k] && (b != 0); ev_note[k] = pend_note[k];
          have_note[k] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) model_reset(k);
      else model_edge(k, midi_valid, int'(midi_data), int'(wave_sel));
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("omni_data",   32'(sd_a), 32'(exp_data[0]));
      check("omni_valid",  32'(sv_a), 32'(exp_valid[0]));
      check("omni_active", 32'(va_a), {act[0][3], act[0][2], act[0][1], act[0][0]});
      check("ch0_data",    32'(sd_b), 32'(exp_data[1]));
      check("ch0_valid",   32'(sv_b), 32'(exp_valid[1]));
      check("ch0_active",  32'(va_b), {act[1][3], act[1][2], act[1][1], act[1][0]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    midi_data  = b;
    midi_valid = 1'b1;
    @(negedge clk);
    midi_valid = 1'b0;
    midi_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_active_a", 32'(va_a), 32'h0);
    check("rst_active_b", 32'(va_b), 32'h0);
    check("rst_data_a",   32'(sd_a), 32'h8000);
    check("rst_valid_a",  32'(sv_a), 32'h0);
    idle(2);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    check("freq_69",  32'(model_freq(69)), 32'd440);
    check("freq_60",  32'(model_freq(60)), 32'd261);
    check("freq_127", 32'(model_freq(127)), 32'd12544);
    check("freq_0",   32'(model_freq(0)), 32'd8);

    idle(2);
    check("init_data",   32'(sd_a), 32'h8000);
    check("init_valid",  32'(sv_a), 32'h0);
    check("init_active", 32'(va_a), 32'h0);
    cmp_en = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(sv_a), 32'h1);
    check("post_rst_data",  32'(sd_a), 32'h8000);

    // Single note, saw wave.
    send(8'h90); send(8'h45); send(8'h64);
    idle(1);
    check("note69_active_a", 32'(va_a), 32'h1);
    check("note69_active_b", 32'(va_b), 32'h1);
    idle(1);
    check("note69_first", 32'(sd_a), 32'h6000);
    idle(1);
    check("note69_second", 32'(sd_a), 32'h6001);

    // Running status.
    apply_reset();
    send(8'h90); send(8'h40); send(8'h40); send(8'h43); send(8'h40);
    idle(2);
    check("rs_two_on", 32'(va_a), 32'h3);
    send(8'h45); send(8'h00);
    idle(2);
    check("rs_vel0_unheld", 32'(va_a), 32'h3);
    send(8'h80); send(8'h40); send(8'h00);
    idle(2);
    check("rs_off", 32'(va_a), 32'h2);

    // Stealing: 60..64 fill then steal voice 0, 65 steals voice 1.
    apply_reset();
    send(8'h90);
    for (int n = 60; n <= 65; n++) begin
      send(8'(n)); send(8'h40);
    end
    idle(2);
    check("steal_full", 32'(va_a), 32'hF);
    send(8'h80); send(8'd64); send(8'h00);
    idle(2);
    check("steal_v0_holds_64", 32'(va_a), 32'hE);
    send(8'd65); send(8'h00);
    idle(2);
    check("steal_v1_holds_65", 32'(va_a), 32'hC);

    // Channel filtering on the channel-0 instance.
    apply_reset();
    send(8'h91); send(8'h40); send(8'h40);
    idle(2);
    check("filt_ch1_b", 32'(va_b), 32'h0);
    check("filt_ch1_a", 32'(va_a), 32'h1);
    send(8'h90); send(8'hF8); send(8'h40); send(8'hFE); send(8'h40);
    idle(2);
    check("filt_rt_b", 32'(va_b), 32'h1);
    send(8'hB0); send(8'h07); send(8'h40);
    idle(2);
    check("filt_cc_b", 32'(va_b), 32'h1);
    check("filt_cc_a", 32'(va_a), 32'h1);

    // Retrigger coinciding with a tick clears rather than advances.
    apply_reset();
    send(8'h90); send(8'h45); send(8'h40);
    idle(5);
    send(8'h45); send(8'h40);
    idle(1);
    check("retrig_active", 32'(va_a), 32'h1);
    idle(1);
    check("retrig_acc_zero", 32'(sd_a), 32'h6000);

    // Randomized traffic.
    apply_reset();
    for (int i = 0; i < 2500; i++) begin
      int r;
      logic [7:0] b;
      if (i == 1200) apply_reset();
      if ($urandom_range(0, 49) == 0) wave_sel = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 8) begin
        idle(1);
      end else begin
        if (r < 18)      b = 8'h80 | 8'($urandom_range(0, 1) << 4) | 8'($urandom_range(0, 1));
        else if (r < 21) b = 8'($urandom_range(8'hA0, 8'hF7));
        else if (r < 25) b = 8'($urandom_range(8'hF8, 8'hFF));
        else if (r < 35) b = 8'h00;
        else if (r < 40) b = 8'($urandom_range(0, 127));
        else             b = 8'(60 + $urandom_range(0, 9));
        send(b);
      end
    end
    idle(10);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
